// File: rtl/tdma_slot_scheduler.sv
// tdma_slot_scheduler
// Shares one downstream resource among three requesters with a 7-slot TDMA
// frame. Each slot has a programmable owner; when the owner is idle (or the
// slot is unowned) the slot is lent to the other requesters in round-robin
// order so that no bandwidth is wasted. Grants are registered and one-hot.

module tdma_slot_scheduler #(
  parameter int SLOT_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic       cfg_we,
  input  logic [2:0] cfg_slot,
  input  logic [1:0] cfg_owner,
  output logic [2:0] grant,
  output logic       owned,
  output logic [2:0] slot,
  output logic       frame_start
);

  localparam logic [7:0] LAST_CYC  = 8'(SLOT_CYCLES - 1);
  localparam logic [2:0] LAST_SLOT = 3'd6;
  localparam logic [1:0] UNOWNED   = 2'd3;

  logic [1:0] owners [7];
  logic [7:0] cyc;
  logic [1:0] ptr;

  logic [1:0] owner;
  logic       owner_hit;
  logic       rr_hit;
  logic [1:0] rr_idx;
  logic [2:0] rr_sum;
  logic       slot_end;

  assign slot_end = (cyc == LAST_CYC);

  // Slot table: restored to its default owner pattern on reset, rewritten
  // by the config port at any time (a slot index of 7 is silently dropped).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owners <= '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    end else if (cfg_we && (cfg_slot <= LAST_SLOT)) begin
      owners[cfg_slot] <= cfg_owner;
    end
  end

  // Slot timing: cyc counts clocks within a slot, slot walks 0..6, and
  // frame_start flags the first cycle after the 6->0 wrap. All freeze
  // while the scheduler is disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc         <= '0;
      slot        <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      frame_start <= slot_end && (slot == LAST_SLOT);
      if (slot_end) begin
        cyc  <= '0;
        slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
      end else begin
        cyc <= cyc + 8'd1;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Decision logic: does the slot owner want the resource, and if not,
  // which requester is first in round-robin order starting at ptr.
  always_comb begin
    owner     = owners[slot];
    owner_hit = 1'b0;
    rr_hit    = 1'b0;
    rr_idx    = 2'd0;
    rr_sum    = 3'd0;
    if (owner != UNOWNED) begin
      owner_hit = req[owner];
    end
    for (int k = 2; k >= 0; k--) begin
      rr_sum = {1'b0, ptr} + 3'(k);
      if (rr_sum >= 3'd3) begin
        rr_sum = rr_sum - 3'd3;
      end
      if (req[rr_sum[1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = rr_sum[1:0];
      end
    end
  end

  // Registered grant: owner first, otherwise round-robin backup which also
  // moves the pointer past the requester that just got served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant <= '0;
      owned <= 1'b0;
      ptr   <= '0;
    end else if (!enable) begin
      grant <= '0;
      owned <= 1'b0;
    end else if (owner_hit) begin
      grant <= 3'b001 << owner;
      owned <= 1'b1;
    end else if (rr_hit) begin
      grant <= 3'b001 << rr_idx;
      owned <= 1'b0;
      ptr   <= (rr_idx == 2'd2) ? 2'd0 : rr_idx + 2'd1;
    end else begin
      grant <= '0;
      owned <= 1'b0;
    end
  end

endmodule

// File: doc/tdma_slot_scheduler.md
# tdma_slot_scheduler

Time-division scheduler that shares one downstream resource among three requesters using a 7-slot frame. The slot position comes from an internal modulo-7 slot counter advanced every SLOT_CYCLES clocks. A programmable slot table names the owner of each slot. Idle slots are handed to other requesters in round-robin order, so unused bandwidth is not lost. Sits between the requesting blocks and the shared resource, and drives its one-hot grant lines.

## Interface
- SLOT_CYCLES, 4, clocks per slot; legal range 1..255.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  global reset; asynchronous, active-high.
- enable  input  1  run control; when low, the scheduler freezes and issues no grants.
- req  input  3  per-requester request level; bit i = requester i.
- cfg_we  input  1  slot-table write strobe.
- cfg_slot  input  3  slot index to write, 0..6; value 7 is ignored.
- cfg_owner  input  2  new owner; 0..2 = requester id, 3 = unowned slot.
- grant  output  3  registered one-hot grant, or all zero.
- owned  output  1  high when the current grant goes to the scheduled owner of the slot.
- slot  output  3  current slot index, 0..6.
- frame_start  output  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- Reset table: slots 0..6 hold owners 0, 1, 2, 0, 1, 2, 3.
- Reset values of other state:
  - grant = 0, owned = 0, slot = 0, frame_start = 0.
  - cycle counter = 0.
  - round-robin pointer = 0.
- Reset forces all of this immediately, even mid-slot or mid-frame. The table is restored to its reset contents.
- Cycle counter `cyc`, width 8:
  - Counts only while enable = 1.
  - At cyc == SLOT_CYCLES-1, cyc wraps to 0 and slot advances.
  - Slot advances 0→1→…→6→0. Values above 6 never occur.
- frame_start is registered. It is 1 exactly in the cycle after slot changes 6→0, and 0 otherwise.
- Grant rule, evaluated each enabled cycle from the current slot, current table entry and current req (owner = table[slot]):
  - If owner < 3 and req[owner] = 1: grant owner, owned = 1.
  - Otherwise, if any req bit is set: grant the first requesting index found by searching from the round-robin pointer upward, mod 3. owned = 0. The pointer becomes (granted+1) mod 3.
  - Otherwise: grant = 0, owned = 0, pointer unchanged.
- The pointer changes only on round-robin (backup) grants, never on owner grants.
- enable = 0:
  - cyc, slot and pointer hold their values.
  - grant and owned go to 0 on the next edge.
  - frame_start = 0.
- Config write:
  - cfg_we = 1 with cfg_slot ≤ 6 writes the table at the edge.
  - The new entry is used by grant evaluation from the next cycle on.
  - A write to the current slot therefore changes grants one cycle later.
  - Writes are accepted regardless of enable.
  - cfg_slot = 7 has no effect.

## Timing
- Grant latency: one cycle. grant at cycle n+1 reflects req, slot and table at cycle n.
- At a slot boundary, grant lags the slot output by one cycle: the first cycle of a new slot still shows the previous slot's decision.
- Dropping a request removes its grant one cycle later.
- Requesters must hold req until granted. There is no request queueing.
- SLOT_CYCLES = 1: slot advances every enabled cycle; a frame is 7 cycles.
- Simultaneous cfg write to table[slot] and slot advance: the write lands in the addressed entry. The next evaluation uses the new slot's entry.
- A frame is 7×SLOT_CYCLES enabled cycles, so frame_start period = 7×SLOT_CYCLES with enable held high.

## Test plan
- Reset, enable = 1, req = 0, SLOT_CYCLES = 4 → slot steps 0..6, each held 4 cycles; frame_start pulses every 28 cycles; grant stays 0.
- req = 3'b111 held → grants follow the table: 001, 010, 100, 001, 010, 100 with owned = 1. Slot 6 gives round-robin 001, then 010, then 100 on successive frames, with owned = 0.
- Slot 0, req = 3'b110 → owner 0 is idle, so round-robin grants 010 then 100 alternately. Each grant appears one cycle after the request.
- Write table[1] = 3 while in slot 1, req = 3'b010 → after the write edge, owned drops to 0 one cycle later, but grant stays 010 via round-robin.
- enable dropped mid-slot 3 (cyc = 2) for 5 cycles → grant = 0 from the next edge; slot and cyc hold 3 and 2. Slot resumes at 3 and advances after 1 more enabled cycle beyond the resumption point.
- Assert reset asynchronously mid-slot 5 with grant = 100 → grant, slot and frame_start become 0 without waiting for a clock edge. The table returns to 0, 1, 2, 0, 1, 2, 3.
